pp_mem_arb: RTL
===============

# pp_mem_arb

Single-port memory arbiter and access sequencer for the five-stage pipeline. It shares one unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port. It inserts a fixed number of wait states per access and returns one-cycle acknowledges. It produces the stall that holds the pipeline registers while an access is outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYC, 2, extra memory wait cycles per access (0 allowed)

Ports:
- clk  in  1  pipeline clock
- rstb  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; level, held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  fetched instruction; valid on if_ack, held until next ack
- if_ack  out  1  one-cycle fetch completion pulse
- dm_rd_en  in  1  load request; level
- dm_wr_en  in  1  store request; level (never together with dm_rd_en)
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; valid on dm_ack, held until next ack
- dm_ack  out  1  one-cycle data completion pulse
- flush  in  1  taken branch; squashes a fetch
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in last access cycle
- stall  out  1  pipeline hold

## Operation
- FSM states: IDLE, ACC, RESP. Registered owner bit `own` (0 = IF, 1 = DM) and wait counter `wcnt`, width max(1, clog2(WAIT_CYC+1)).
- IDLE: when DM is requested (dm_rd_en|dm_wr_en), grant DM. Otherwise grant IF when if_req & ~flush. On a grant, latch `own`, the address, the write data and the write flag, clear wcnt, and go to ACC. With no request, stay in IDLE.
- ACC: mem_en=1, mem_we=latched write flag, and mem_addr/mem_wdata come from the latches. Increment wcnt each cycle. When wcnt==WAIT_CYC, capture mem_rdata into the owner's rdata register (only for a read) and go to RESP.
- RESP: pulse the owner's ack for 1 cycle, then return to IDLE. Requests are not sampled in RESP. Requesters drop or change their request in the cycle after ack.
- Flush: in ACC with own=IF, go to IDLE next cycle. if_ack is not issued and if_rdata keeps its old value. A DM access is never aborted. flush in RESP with own=IF suppresses if_ack.
- stall = (if_req & ~if_ack & ~flush) | ((dm_rd_en|dm_wr_en) & ~dm_ack). This is combinational from the registered state.
- Reset (async, mid-access included): state IDLE, wcnt 0, own 0, all latches 0. if_rdata, dm_rdata, both acks, mem_en and mem_we are 0. No ack is produced for an aborted access.

## Timing
- A request is seen in IDLE at cycle 0. ACC runs in cycles 1..WAIT_CYC+1, and the ack arrives in cycle WAIT_CYC+2.
- Minimum spacing between grants is WAIT_CYC+3 cycles.
- Conflict in IDLE: DM wins. IF waits one full access.
- With WAIT_CYC=0: one ACC cycle, ack in cycle 2.
- All outputs except stall are registered or decoded from registered state.

## Configuration
- PP_MEM_ARB_FAIR_EN defined: a registered `last` bit records the last granted owner. On a simultaneous IF/DM request in IDLE, the port that was not last granted wins. `last` resets to IF, so DM wins the first conflict.
- PP_MEM_ARB_FAIR_EN undefined: fixed DM priority as above. The `last` register is absent.

## Structure
- Shared package pp_pkg: FSM state enum (IDLE/ACC/RESP) and owner constants OWN_IF=0, OWN_DM=1.
- One sub-module, pp_wait_cnt: a parameterised wait counter with clear and terminal-count output.
- The remaining logic is a single always_ff FSM plus the output decode.

## Test plan
- Lone fetch: WAIT_CYC=2, if_req at cycle 0, addr 0x40, mem returns 0x8C220004. Expect mem_en high in cycles 1–3, if_ack and if_rdata=0x8C220004 in cycle 4, and stall high in cycles 0–3.
- Store: dm_wr_en, addr 0x100, wdata 0xDEADBEEF. Expect mem_we=1 in cycles 1–3, dm_ack in cycle 4, and dm_rdata unchanged.
- Conflict: if_req and dm_rd_en both at cycle 0. Expect dm_ack in cycle 4 and if_ack in cycle 9. With PP_MEM_ARB_FAIR_EN, a second simultaneous conflict grants IF first.
- Flush: flush pulsed in cycle 2 of a fetch. Expect mem_en low from cycle 3, no if_ack, and if_rdata holding its prior value. The same flush during a load leaves dm_ack in cycle 4.
- Reset mid-access: rstb low in cycle 2. Expect all outputs 0 immediately and no ack. After release, a new request completes normally.
- WAIT_CYC=0: a load yields mem_en only in cycle 1 and dm_ack in cycle 2.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared types and constants for the pipeline memory arbiter.
// Latency: none (package only).
// Backpressure: none (package only).
package pp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Counter width able to hold 0..wait_cyc, never narrower than one bit.
    function automatic int cnt_width(input int wait_cyc);
        return (wait_cyc < 1) ? 1 : $clog2(wait_cyc + 1);
    endfunction

endpackage

// File: rtl/pp_wait_cnt.sv
// Wait-state counter: clears on a grant, counts up while enabled, flags terminal count.
// Latency: done is decoded combinationally from the registered count.
// Backpressure: none; the owner FSM decides when to clear and enable.
module pp_wait_cnt #(
    parameter int W  = 2,
    parameter int TC = 2
) (
    input  logic clk,
    input  logic rstb,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [W-1:0] cnt;

    // Count register: clear wins over increment.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign done = (cnt == W'(TC));

endmodule

// File: rtl/pp_mem_arb.sv
// Single-port memory arbiter between IF fetch and MEM load/store, with fixed wait states.
// Latency: request seen in IDLE at cycle 0, memory busy cycles 1..WAIT_CYC+1, ack in WAIT_CYC+2.
// Backpressure: stall holds the pipeline while a request is pending; PP_MEM_ARB_FAIR_EN selects alternating priority on conflicts.
module pp_mem_arb
    import pp_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_rd_en,
    input  logic              dm_wr_en,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int CNT_W = cnt_width(WAIT_CYC);

    state_t            state_q;
    state_t            state_d;
    logic              own_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic              dm_req;
    logic              if_go;
    logic              pick_if;
    logic              grant;
    logic              grant_own;
    logic              cnt_clr;
    logic              cnt_en;
    logic              wait_done;
    logic              capture;

    assign dm_req = dm_rd_en | dm_wr_en;
    // A fetch that is being squashed this cycle is not worth starting.
    assign if_go  = if_req & ~flush;

`ifdef PP_MEM_ARB_FAIR_EN
    logic last_q;

    // On a conflict, the port that did not win last time goes first.
    assign pick_if = if_go & (~dm_req | (last_q == OWN_DM));

    // Remember the most recent grant for the next conflict.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            last_q <= OWN_IF;
        end else if (grant) begin
            last_q <= grant_own;
        end
    end
`else
    // Data port always beats the fetch port.
    assign pick_if = if_go & ~dm_req;
`endif

    pp_wait_cnt #(
        .W  (CNT_W),
        .TC (WAIT_CYC)
    ) u_wait_cnt (
        .clk  (clk),
        .rstb (rstb),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .done (wait_done)
    );

    // Next-state and grant decode for the access sequencer.
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        grant_own = OWN_DM;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req | if_go) begin
                    grant     = 1'b1;
                    grant_own = pick_if ? OWN_IF : OWN_DM;
                    cnt_clr   = 1'b1;
                    state_d   = ACC;
                end
            end
            ACC: begin
                // A squashed fetch is dropped on the spot; loads/stores always finish.
                if ((own_q == OWN_IF) && flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (wait_done) begin
                        capture = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant latches and per-port read-data holding registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= IDLE;
            own_q      <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                own_q   <= grant_own;
                addr_q  <= (grant_own == OWN_IF) ? if_addr : dm_addr;
                wdata_q <= (grant_own == OWN_DM) ? dm_wdata : '0;
                we_q    <= (grant_own == OWN_DM) & dm_wr_en;
            end
            if (capture && !we_q) begin
                if (own_q == OWN_IF) begin
                    if_rdata_q <= mem_rdata;
                end else begin
                    dm_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = (state_q == ACC);
    assign mem_we    = (state_q == ACC) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    // A flush arriving in the response cycle still kills the fetch ack.
    assign if_ack = (state_q == RESP) & (own_q == OWN_IF) & ~flush;
    assign dm_ack = (state_q == RESP) & (own_q == OWN_DM);

    assign stall = (if_req & ~if_ack & ~flush) | (dm_req & ~dm_ack);

endmodule
